mem_cmd_arbiter: RTL and testbench

// Shares the single DDR3 MIG command port between the video-input framebuffer writer and the EPDC frame

---
 rtl/mem_cmd_arbiter_if.sv | 38 +++
 rtl/mem_cmd_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_cmd_arbiter.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_cmd_arbiter_if.sv
// Command-port bundle between the vin/epdc DMA engines, the arbiter and the MIG.
// slave: arbiter side. master: requester/MIG side (used by models and benches).
interface mem_cmd_arbiter_if #(
    parameter int ADDR_W = 30,
    parameter int BL_W   = 6
);
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [BL_W-1:0]   rd_bl;
    logic              rd_ack;
    logic              rd_done;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [BL_W-1:0]   wr_bl;
    logic              wr_ack;
    logic [6:0]        wr_data_count;
    logic              cmd_full;
    logic              cmd_en;
    logic [2:0]        cmd_instr;
    logic [BL_W-1:0]   cmd_bl;
    logic [ADDR_W-1:0] cmd_byte_addr;
    logic [2:0]        rd_outst;
    logic              err_underflow;

    modport slave (
        input  rd_req, rd_addr, rd_bl, rd_done,
        input  wr_req, wr_addr, wr_bl, wr_data_count, cmd_full,
        output rd_ack, wr_ack, cmd_en, cmd_instr, cmd_bl, cmd_byte_addr,
        output rd_outst, err_underflow
    );

    modport master (
        output rd_req, rd_addr, rd_bl, rd_done,
        output wr_req, wr_addr, wr_bl, wr_data_count, cmd_full,
        input  rd_ack, wr_ack, cmd_en, cmd_instr, cmd_bl, cmd_byte_addr,
        input  rd_outst, err_underflow
    );
endinterface

// File: rtl/mem_cmd_arbiter.sv
// Shares the single MIG command port between the video-in writer and the EPDC reader.
// Reads win by default; a starvation counter guarantees the writer a slot, writes only
// go once their data is already in the MIG write FIFO, and read bursts in flight are capped.
//
// state  | meaning
// IDLE   | evaluate eligibility, latch the chosen command into cmd_*
// ISSUE  | strobe cmd_en on the first cycle the MIG command FIFO has room
// GAP    | one dead cycle so the requester can drop/refresh its request after ack
module mem_cmd_arbiter #(
    parameter int ADDR_W     = 30,
    parameter int BL_W       = 6,
    parameter int STARVE_MAX = 8,
    parameter int MAX_OUTST  = 4
) (
    input  logic               clk,
    input  logic               rstn,
    mem_cmd_arbiter_if.slave   bus
);
    localparam int SC_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [SC_W-1:0]   starve_cnt;
    logic [2:0]        rd_outst;
    logic              err_q;
    logic [2:0]        instr_q;
    logic [BL_W-1:0]   bl_q;
    logic [ADDR_W-1:0] addr_q;
    logic              sel_wr_ok;
    logic              rd_ok, wr_ok, starve_sat;
    logic              sel_rd, sel_wr, fire, issue_rd;

    assign rd_ok      = bus.rd_req && (rd_outst < 3'(MAX_OUTST));
    assign wr_ok      = bus.wr_req && (int'(bus.wr_data_count) > int'(bus.wr_bl));
    assign starve_sat = (starve_cnt == SC_W'(STARVE_MAX));
    assign issue_rd   = fire && instr_q[0];

    assign bus.cmd_en        = fire;
    assign bus.rd_ack        = issue_rd;
    assign bus.wr_ack        = fire && !instr_q[0];
    assign bus.cmd_instr     = instr_q;
    assign bus.cmd_bl        = bl_q;
    assign bus.cmd_byte_addr = addr_q;
    assign bus.rd_outst      = rd_outst;
    assign bus.err_underflow = err_q;

    // state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // next-state, selection and issue strobe; a selected command is never withdrawn
    always_comb begin
        state_nxt = state;
        sel_rd    = 1'b0;
        sel_wr    = 1'b0;
        fire      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (wr_ok && (!rd_ok || starve_sat)) begin
                    sel_wr    = 1'b1;
                    state_nxt = ST_ISSUE;
                end else if (rd_ok) begin
                    sel_rd    = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!bus.cmd_full) begin
                    fire      = 1'b1;
                    state_nxt = ST_GAP;
                end
            end
            ST_GAP:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // latch the chosen command; fields hold until the next selection
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            instr_q   <= 3'b000;
            bl_q      <= '0;
            addr_q    <= '0;
            sel_wr_ok <= 1'b0;
        end else if (sel_wr) begin
            instr_q   <= 3'b000;
            bl_q      <= bus.wr_bl;
            addr_q    <= bus.wr_addr;
            sel_wr_ok <= 1'b1;
        end else if (sel_rd) begin
            instr_q   <= 3'b001;
            bl_q      <= bus.rd_bl;
            addr_q    <= bus.rd_addr;
            sel_wr_ok <= wr_ok;
        end
    end

    // count reads that jumped ahead of an eligible write; a write issue clears it
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            starve_cnt <= '0;
        end else if (fire && !instr_q[0]) begin
            starve_cnt <= '0;
        end else if (issue_rd && sel_wr_ok && !starve_sat) begin
            starve_cnt <= starve_cnt + SC_W'(1);
        end
    end

    // outstanding read bursts; a drain with nothing in flight is flagged and ignored
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_outst <= 3'd0;
            err_q    <= 1'b0;
        end else begin
            if (bus.rd_done && (rd_outst == 3'd0)) err_q <= 1'b1;
            case ({issue_rd, bus.rd_done})
                2'b10:   rd_outst <= rd_outst + 3'd1;
                2'b01:   if (rd_outst != 3'd0) rd_outst <= rd_outst - 3'd1;
                default: rd_outst <= rd_outst;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_cmd_arbiter.sv
// Bench for mem_cmd_arbiter: directed scenarios plus a randomized run against a
// transaction-level reference model (pending command / dead cycle / counters).
module tb_mem_cmd_arbiter;
    localparam int ADDR_W     = 30;
    localparam int BL_W       = 6;
    localparam int STARVE_MAX = 8;
    localparam int MAX_OUTST  = 4;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int checks   = 0;
    int failures = 0;

    bit                m_pend, m_pend_rd, m_pend_wrok, m_gap, m_err;
    int                m_outst, m_starve;
    logic [ADDR_W-1:0] m_addr;
    logic [BL_W-1:0]   m_bl;

    mem_cmd_arbiter_if #(.ADDR_W(ADDR_W), .BL_W(BL_W)) bus ();

    mem_cmd_arbiter #(
        .ADDR_W(ADDR_W), .BL_W(BL_W), .STARVE_MAX(STARVE_MAX), .MAX_OUTST(MAX_OUTST)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no summary by time limit, required completion");
        $fatal(1, "time limit");
    end

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_idle();
        bus.rd_req = 1'b0; bus.rd_addr = '0; bus.rd_bl = '0; bus.rd_done = 1'b0;
        bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_bl = '0; bus.wr_data_count = '0;
        bus.cmd_full = 1'b0;
    endtask

    task automatic do_reset();
        drive_idle();
        rstn = 1'b0;
        repeat (2) next_cycle();
        rstn = 1'b1;
        next_cycle();
    endtask

    task automatic wait_cmd(input int max_cyc, output bit got, output logic [2:0] instr);
        got = 1'b0;
        instr = 3'b111;
        for (int c = 0; c < max_cyc; c++) begin
            #1;
            if (bus.cmd_en) begin
                got = 1'b1;
                instr = bus.cmd_instr;
                return;
            end
            next_cycle();
        end
    endtask

    task automatic test_reset();
        drive_idle();
        rstn = 1'b0;
        repeat (2) next_cycle();
        #1;
        checks++;
        if ({bus.cmd_en, bus.rd_ack, bus.wr_ack} !== 3'b000) begin
            failures++; $display("FAIL reset_strobes: got %b required 000", {bus.cmd_en, bus.rd_ack, bus.wr_ack});
        end
        checks++;
        if ({bus.cmd_instr, bus.cmd_bl, bus.cmd_byte_addr} !== '0) begin
            failures++; $display("FAIL reset_fields: got %h required 0", {bus.cmd_instr, bus.cmd_bl, bus.cmd_byte_addr});
        end
        checks++;
        if (bus.rd_outst !== 3'd0) begin
            failures++; $display("FAIL reset_outst: got %0d required 0", bus.rd_outst);
        end
        checks++;
        if (bus.err_underflow !== 1'b0) begin
            failures++; $display("FAIL reset_err: got %b required 0", bus.err_underflow);
        end
        rstn = 1'b1;
        next_cycle();
        #1;
        checks++;
        if (bus.cmd_en !== 1'b0) begin
            failures++; $display("FAIL reset_idle_cmd_en: got %b required 0", bus.cmd_en);
        end
    endtask

    task automatic test_single_read();
        do_reset();
        bus.rd_req = 1'b1; bus.rd_addr = ADDR_W'(32'h100); bus.rd_bl = BL_W'(15);
        #1;
        checks++;
        if (bus.cmd_en !== 1'b0) begin
            failures++; $display("FAIL read_early_cmd_en: got %b required 0", bus.cmd_en);
        end
        next_cycle();
        #1;
        checks++;
        if ({bus.cmd_en, bus.rd_ack, bus.wr_ack} !== 3'b110) begin
            failures++; $display("FAIL read_strobes: got %b required 110", {bus.cmd_en, bus.rd_ack, bus.wr_ack});
        end
        checks++;
        if ({bus.cmd_instr, bus.cmd_bl, bus.cmd_byte_addr} !== {3'b001, BL_W'(15), ADDR_W'(32'h100)}) begin
            failures++; $display("FAIL read_fields: got instr=%b bl=%0d addr=%h required 001/15/100",
                                 bus.cmd_instr, bus.cmd_bl, bus.cmd_byte_addr);
        end
        next_cycle();
        bus.rd_req = 1'b0;
        #1;
        checks++;
        if ({bus.cmd_en, bus.rd_outst} !== {1'b0, 3'd1}) begin
            failures++; $display("FAIL read_after: got cmd_en=%b outst=%0d required 0/1", bus.cmd_en, bus.rd_outst);
        end
        bus.rd_done = 1'b1;
        next_cycle();
        bus.rd_done = 1'b0;
        #1;
        checks++;
        if (bus.rd_outst !== 3'd0) begin
            failures++; $display("FAIL read_drain: got %0d required 0", bus.rd_outst);
        end
    endtask

    task automatic test_write_threshold();
        do_reset();
        bus.wr_req = 1'b1; bus.wr_addr = ADDR_W'(32'h2000); bus.wr_bl = BL_W'(7); bus.wr_data_count = 7'd7;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (bus.cmd_en !== 1'b0) begin
                failures++; $display("FAIL wr_short_blocked: cycle %0d got cmd_en=%b required 0", c, bus.cmd_en);
            end
            next_cycle();
        end
        bus.wr_data_count = 7'd8;
        next_cycle();
        #1;
        checks++;
        if ({bus.cmd_en, bus.wr_ack, bus.rd_ack} !== 3'b110) begin
            failures++; $display("FAIL wr_strobes: got %b required 110", {bus.cmd_en, bus.wr_ack, bus.rd_ack});
        end
        checks++;
        if ({bus.cmd_instr, bus.cmd_bl, bus.cmd_byte_addr} !== {3'b000, BL_W'(7), ADDR_W'(32'h2000)}) begin
            failures++; $display("FAIL wr_fields: got instr=%b bl=%0d addr=%h required 000/7/2000",
                                 bus.cmd_instr, bus.cmd_bl, bus.cmd_byte_addr);
        end
        next_cycle();
        bus.wr_req = 1'b0;
    endtask

    task automatic test_starvation();
        bit seq [18];
        int n = 0;
        bit done_next = 1'b0;
        do_reset();
        bus.rd_req = 1'b1; bus.rd_addr = ADDR_W'(32'h40); bus.rd_bl = BL_W'(7);
        bus.wr_req = 1'b1; bus.wr_addr = ADDR_W'(32'h8000); bus.wr_bl = BL_W'(3); bus.wr_data_count = 7'd64;
        for (int c = 0; c < 200 && n < 18; c++) begin
            bus.rd_done = done_next;
            done_next = 1'b0;
            #1;
            if (bus.cmd_en) begin
                seq[n] = bus.cmd_instr[0];
                if (bus.cmd_instr[0]) done_next = 1'b1;
                n++;
            end
            next_cycle();
        end
        bus.rd_done = done_next;
        next_cycle();
        drive_idle();
        checks++;
        if (n != 18) begin
            failures++; $display("FAIL starve_issue_count: got %0d required 18", n);
        end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (seq[i] !== ((i % 9) != 8)) begin
                failures++; $display("FAIL starve_pattern: issue %0d got read=%b required read=%b", i, seq[i], (i % 9) != 8);
            end
        end
    endtask

    task automatic test_outstanding();
        int nrd = 0;
        bit got;
        logic [2:0] instr;
        do_reset();
        bus.rd_req = 1'b1; bus.rd_addr = ADDR_W'(32'h40); bus.rd_bl = BL_W'(3);
        for (int c = 0; c < 40; c++) begin
            #1;
            if (bus.cmd_en) nrd++;
            next_cycle();
        end
        #1;
        checks++;
        if ({nrd, bus.rd_outst} !== {32'd4, 3'd4}) begin
            failures++; $display("FAIL outst_cap: got reads=%0d outst=%0d required 4/4", nrd, bus.rd_outst);
        end
        bus.wr_req = 1'b1; bus.wr_addr = ADDR_W'(32'h500); bus.wr_bl = BL_W'(1); bus.wr_data_count = 7'd5;
        wait_cmd(10, got, instr);
        checks++;
        if ({got, instr} !== {1'b1, 3'b000}) begin
            failures++; $display("FAIL outst_write_passes: got issued=%b instr=%b required 1/000", got, instr);
        end
        next_cycle();
        bus.wr_req = 1'b0;
        bus.rd_done = 1'b1;
        next_cycle();
        bus.rd_done = 1'b0;
        #1;
        checks++;
        if (bus.rd_outst !== 3'd3) begin
            failures++; $display("FAIL outst_drain: got %0d required 3", bus.rd_outst);
        end
        wait_cmd(10, got, instr);
        checks++;
        if ({got, instr} !== {1'b1, 3'b001}) begin
            failures++; $display("FAIL outst_read_resumes: got issued=%b instr=%b required 1/001", got, instr);
        end
        next_cycle();
        bus.rd_req = 1'b0;
        #1;
        checks++;
        if (bus.rd_outst !== 3'd4) begin
            failures++; $display("FAIL outst_refill: got %0d required 4", bus.rd_outst);
        end
    endtask

    task automatic test_cmd_full();
        bit got;
        logic [2:0] instr;
        do_reset();
        bus.rd_req = 1'b1; bus.rd_addr = ADDR_W'(32'h300); bus.rd_bl = BL_W'(5);
        wait_cmd(10, got, instr);
        next_cycle();
        bus.cmd_full = 1'b1;
        bus.rd_addr = ADDR_W'(32'h480); bus.rd_bl = BL_W'(9);
        repeat (2) next_cycle();
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if ({bus.cmd_en, bus.rd_ack, bus.cmd_instr, bus.cmd_bl, bus.cmd_byte_addr} !==
                {1'b0, 1'b0, 3'b001, BL_W'(9), ADDR_W'(32'h480)}) begin
                failures++; $display("FAIL full_hold: cycle %0d got en=%b ack=%b instr=%b bl=%0d addr=%h required 0/0/001/9/480",
                                     c, bus.cmd_en, bus.rd_ack, bus.cmd_instr, bus.cmd_bl, bus.cmd_byte_addr);
            end
            next_cycle();
        end
        bus.cmd_full = 1'b0;
        bus.rd_done = 1'b1;
        #1;
        checks++;
        if ({bus.cmd_en, bus.rd_ack} !== 2'b11) begin
            failures++; $display("FAIL full_release: got %b required 11", {bus.cmd_en, bus.rd_ack});
        end
        next_cycle();
        bus.rd_done = 1'b0;
        bus.rd_req = 1'b0;
        #1;
        checks++;
        if ({bus.cmd_en, bus.rd_outst} !== {1'b0, 3'd1}) begin
            failures++; $display("FAIL full_single_pulse_outst: got en=%b outst=%0d required 0/1", bus.cmd_en, bus.rd_outst);
        end
    endtask

    task automatic test_reset_in_issue();
        bit got;
        logic [2:0] instr;
        do_reset();
        bus.rd_req = 1'b1; bus.rd_addr = ADDR_W'(32'h10); bus.rd_bl = BL_W'(1);
        wait_cmd(10, got, instr);
        next_cycle();
        wait_cmd(10, got, instr);
        next_cycle();
        bus.cmd_full = 1'b1;
        repeat (2) next_cycle();
        #1;
        checks++;
        if ({bus.cmd_en, bus.rd_outst} !== {1'b0, 3'd2}) begin
            failures++; $display("FAIL rst_pre: got en=%b outst=%0d required 0/2", bus.cmd_en, bus.rd_outst);
        end
        bus.cmd_full = 1'b0;
        #1;
        checks++;
        if (bus.cmd_en !== 1'b1) begin
            failures++; $display("FAIL rst_pre_issue: got %b required 1", bus.cmd_en);
        end
        rstn = 1'b0;
        #1;
        checks++;
        if ({bus.cmd_en, bus.rd_ack, bus.wr_ack, bus.rd_outst} !== {3'b000, 3'd0}) begin
            failures++; $display("FAIL rst_async: got en/acks=%b outst=%0d required 000/0",
                                 {bus.cmd_en, bus.rd_ack, bus.wr_ack}, bus.rd_outst);
        end
        drive_idle();
        next_cycle();
        rstn = 1'b1;
        next_cycle();
        bus.rd_done = 1'b1;
        next_cycle();
        bus.rd_done = 1'b0;
        #1;
        checks++;
        if ({bus.err_underflow, bus.rd_outst} !== {1'b1, 3'd0}) begin
            failures++; $display("FAIL underflow: got err=%b outst=%0d required 1/0", bus.err_underflow, bus.rd_outst);
        end
    endtask

    task automatic test_random();
        bit exp_fire, ack_rd, ack_wr, rd_ok, wr_ok;
        int nxt;
        do_reset();
        m_pend = 0; m_pend_rd = 0; m_pend_wrok = 0; m_gap = 0; m_err = 0;
        m_outst = 0; m_starve = 0; m_addr = '0; m_bl = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!bus.rd_req && $urandom_range(0, 2) == 0) begin
                bus.rd_req = 1'b1; bus.rd_addr = ADDR_W'($urandom); bus.rd_bl = BL_W'($urandom);
            end
            if (!bus.wr_req && $urandom_range(0, 3) == 0) begin
                bus.wr_req = 1'b1; bus.wr_addr = ADDR_W'($urandom); bus.wr_bl = BL_W'($urandom);
            end
            case ($urandom_range(0, 3))
                0:       bus.wr_data_count = 7'(bus.wr_bl);
                1, 2:    bus.wr_data_count = 7'(bus.wr_bl) + 7'd1;
                default: bus.wr_data_count = 7'($urandom);
            endcase
            bus.cmd_full = ($urandom_range(0, 3) == 0);
            bus.rd_done  = (m_outst > 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 49) == 0);
            #1;
            exp_fire = m_pend && !bus.cmd_full;
            ack_rd = exp_fire && m_pend_rd;
            ack_wr = exp_fire && !m_pend_rd;
            checks++;
            if ({bus.cmd_en, bus.rd_ack, bus.wr_ack} !== {exp_fire, ack_rd, ack_wr}) begin
                failures++; $display("FAIL rand_strobes: cycle %0d got %b required %b", cyc,
                                     {bus.cmd_en, bus.rd_ack, bus.wr_ack}, {exp_fire, ack_rd, ack_wr});
            end
            checks++;
            if (bus.rd_outst !== 3'(m_outst)) begin
                failures++; $display("FAIL rand_outst: cycle %0d got %0d required %0d", cyc, bus.rd_outst, m_outst);
            end
            checks++;
            if (bus.err_underflow !== m_err) begin
                failures++; $display("FAIL rand_err: cycle %0d got %b required %b", cyc, bus.err_underflow, m_err);
            end
            if (exp_fire) begin
                checks++;
                if ({bus.cmd_instr, bus.cmd_bl, bus.cmd_byte_addr} !== {(m_pend_rd ? 3'b001 : 3'b000), m_bl, m_addr}) begin
                    failures++; $display("FAIL rand_fields: cycle %0d got %b/%0d/%h required %b/%0d/%h", cyc,
                                         bus.cmd_instr, bus.cmd_bl, bus.cmd_byte_addr,
                                         (m_pend_rd ? 3'b001 : 3'b000), m_bl, m_addr);
                end
            end
            // reference model: the clock edge that follows
            rd_ok = bus.rd_req && (m_outst < MAX_OUTST);
            wr_ok = bus.wr_req && (int'(bus.wr_data_count) > int'(bus.wr_bl));
            if (m_pend) begin
                if (exp_fire) begin
                    m_pend = 0;
                    m_gap = 1;
                end
            end else if (m_gap) begin
                m_gap = 0;
            end else if (wr_ok && (!rd_ok || m_starve == STARVE_MAX)) begin
                m_pend = 1; m_pend_rd = 0; m_addr = bus.wr_addr; m_bl = bus.wr_bl;
            end else if (rd_ok) begin
                m_pend = 1; m_pend_rd = 1; m_pend_wrok = wr_ok; m_addr = bus.rd_addr; m_bl = bus.rd_bl;
            end
            if (ack_wr) m_starve = 0;
            if (ack_rd && m_pend_wrok && m_starve < STARVE_MAX) m_starve++;
            if (bus.rd_done && m_outst == 0) m_err = 1;
            nxt = m_outst + (ack_rd ? 1 : 0) - (bus.rd_done ? 1 : 0);
            m_outst = (nxt < 0) ? 0 : nxt;
            next_cycle();
            if (ack_rd) bus.rd_req = 1'b0;
            if (ack_wr) bus.wr_req = 1'b0;
        end
        drive_idle();
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_single_read();
        test_write_threshold();
        test_starvation();
        test_outstanding();
        test_cmd_full();
        test_reset_in_issue();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
